// File: rtl/div_pkg.sv
// ==== div_pkg : shared types and constants for the sequential divider ==== //
// ==== rev 1.0                                                         ==== //
`default_nettype none

package div_pkg;

  localparam int NUM_W_DEF = 31;
  localparam int DEN_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width needed to hold the values 0 .. value-1, never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ==== div_step : one restoring-division iteration (compare, subtract, shift) ==== //
// ==== rev 1.0                                                                ==== //
`default_nettype none

module div_step
  import div_pkg::*;
#(
  parameter int DEN_W = DEN_W_DEF
) (
  input  logic [DEN_W-1:0] rem_acc,
  input  logic             msb,
  input  logic [DEN_W-1:0] den,
  output logic [DEN_W-1:0] rem_nxt,
  output logic             q_bit
);

  logic [DEN_W:0]   r;
  logic [DEN_W-1:0] diff;

  // When r >= den, r - den < den, so the low DEN_W bits hold the exact difference.
  always_comb begin
    r       = {rem_acc, msb};
    diff    = r[DEN_W-1:0] - den;
    q_bit   = (r >= {1'b0, den});
    rem_nxt = q_bit ? diff : r[DEN_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ==== seq_divider : unsigned restoring divider, one quotient bit per enabled clock ==== //
// ==== rev 1.0                                                                      ==== //
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int DEN_W = DEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo,
  output logic [DEN_W-1:0] rem,
  output logic             div_by_zero
);

  localparam int               CNT_W    = clog2(NUM_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] quo_acc_q, quo_acc_d;
  logic [DEN_W-1:0] rem_acc_q, rem_acc_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [DEN_W-1:0] step_rem;
  logic             step_bit;
  logic [NUM_W-1:0] quo_shift;

  div_step #(
    .DEN_W (DEN_W)
  ) u_step (
    .rem_acc (rem_acc_q),
    .msb     (quo_acc_q[NUM_W-1]),
    .den     (den_q),
    .rem_nxt (step_rem),
    .q_bit   (step_bit)
  );

  // The dividend register doubles as the quotient: bits leave at the top, results enter at the bottom.
  assign quo_shift = {quo_acc_q[NUM_W-2:0], step_bit};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_acc_d = quo_acc_q;
    rem_acc_d = rem_acc_q;
    den_d     = den_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          if (den == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d   = ST_RUN;
            busy_d    = 1'b1;
            den_d     = den;
            quo_acc_d = num;
            rem_acc_d = '0;
            cnt_d     = CNT_LAST;
          end
        end
      end

      ST_RUN: begin
        rem_acc_d = step_rem;
        quo_acc_d = quo_shift;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = quo_shift;
          rem_d   = step_rem;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      quo_acc_q <= '0;
      rem_acc_q <= '0;
      den_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_acc_q <= quo_acc_d;
      rem_acc_q <= rem_acc_d;
      den_q     <= den_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quo         = quo_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ==== tb_seq_divider : self-checking bench for seq_divider ==== //
// ==== rev 1.0                                               ==== //
`default_nettype none

module tb_seq_divider;

  localparam int NUM_W = 31;
  localparam int DEN_W = 12;
  localparam int TMO   = 200;

  typedef struct {
    logic [NUM_W-1:0] quo;
    logic [DEN_W-1:0] rem;
    logic             dbz;
  } exp_t;

  typedef struct {
    logic [NUM_W-1:0] num;
    logic [DEN_W-1:0] den;
    logic [NUM_W-1:0] quo;
    logic [DEN_W-1:0] rem;
    logic             dbz;
    int               lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ce = 1'b1;
  logic             start = 1'b0;
  logic [NUM_W-1:0] num = '0;
  logic [DEN_W-1:0] den = '0;
  logic             busy, done, div_by_zero;
  logic [NUM_W-1:0] quo;
  logic [DEN_W-1:0] rem;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .start       (start),
    .num         (num),
    .den         (den),
    .busy        (busy),
    .done        (done),
    .quo         (quo),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: every rising done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done && !prev_done) begin
      if (sb.size() == 0) begin
        chk("spurious_done_queue_size", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("quo", 64'(quo), 64'(mon_e.quo));
        chk("rem", 64'(rem), 64'(mon_e.rem));
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
      end
    end
    prev_done <= done && rst_n;
  end

  // Issue one operation at the next falling edge; lat is the index of the edge where done rose.
  task automatic run_op(input logic [NUM_W-1:0] n, input logic [DEN_W-1:0] d, input exp_t e,
                        output int lat, output int busy_cnt);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    num   = n;
    den   = d;
    sb.push_back(e);
    cyc      = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) busy_cnt++;
    end while (!done && cyc < TMO);
    lat = cyc - 1;
  endtask

  vec_t vecs[10];

  initial begin
    int   lat, bc, cyc;
    logic stable;

    vecs[0] = '{num: 31'd1000,       den: 12'd7,     quo: 31'd142,        rem: 12'd6,    dbz: 1'b0, lat: 31};
    vecs[1] = '{num: 31'd12345,      den: 12'd0,     quo: 31'h7FFFFFFF,   rem: 12'd0,    dbz: 1'b1, lat: 0};
    vecs[2] = '{num: 31'h7FFFFFFF,   den: 12'd1,     quo: 31'h7FFFFFFF,   rem: 12'd0,    dbz: 1'b0, lat: 31};
    vecs[3] = '{num: 31'd5,          den: 12'd9,     quo: 31'd0,          rem: 12'd5,    dbz: 1'b0, lat: 31};
    vecs[4] = '{num: 31'h7FFFFFFF,   den: 12'hFFF,   quo: 31'h80080,      rem: 12'h07F,  dbz: 1'b0, lat: 31};
    vecs[5] = '{num: 31'd0,          den: 12'd5,     quo: 31'd0,          rem: 12'd0,    dbz: 1'b0, lat: 31};
    vecs[6] = '{num: 31'd81,         den: 12'd9,     quo: 31'd9,          rem: 12'd0,    dbz: 1'b0, lat: 31};
    for (int i = 7; i < 10; i++) begin
      vecs[i].num = 31'($urandom);
      vecs[i].den = 12'($urandom_range(1, 4095));
      vecs[i].quo = vecs[i].num / 31'(vecs[i].den);
      vecs[i].rem = 12'(vecs[i].num % 31'(vecs[i].den));
      vecs[i].dbz = 1'b0;
      vecs[i].lat = 31;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quo", 64'(quo), 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].num, vecs[i].den, '{vecs[i].quo, vecs[i].rem, vecs[i].dbz}, lat, bc);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].dbz ? 0 : 31));
    end

    // Stall of 10 edges starting 5 edges after start, plus an ignored mid-run start
    @(negedge clk);
    start = 1'b1; num = 31'd1000; den = 12'd7;
    sb.push_back('{31'd142, 12'd6, 1'b0});
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      ce    = !(cyc >= 5 && cyc < 15);
      start = (cyc == 20);
      num   = (cyc == 20) ? 31'd999 : 31'd0;
      den   = (cyc == 20) ? 12'd2 : 12'd0;
    end while (!done && cyc < TMO);
    ce = 1'b1; start = 1'b0;
    chk("stall_latency", 64'(cyc - 1), 64'd41);
    repeat (40) @(negedge clk);
    chk("stall_quo_held", 64'(quo), 64'd142);
    chk("stall_rem_held", 64'(rem), 64'd6);

    // Asynchronous reset twelve cycles into a run
    @(negedge clk);
    start = 1'b1; num = 31'd1000; den = 12'd7;
    sb.push_back('{31'd142, 12'd6, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_quo", 64'(quo), 64'd0);
    chk("arst_rem", 64'(rem), 64'd0);
    chk("arst_dbz", 64'(div_by_zero), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(31'd81, 12'd9, '{31'd9, 12'd0, 1'b0}, lat, bc);
    chk("arst_next_latency", 64'(lat), 64'd31);

    // Back-to-back: new start presented during the DONE cycle
    @(negedge clk);
    start = 1'b1; num = 31'd1000; den = 12'd7;
    sb.push_back('{31'd142, 12'd6, 1'b0});
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!done && cyc < TMO);
    chk("b2b_first_latency", 64'(cyc - 1), 64'd31);
    start = 1'b1; num = 31'd100; den = 12'd3;
    sb.push_back('{31'd33, 12'd1, 1'b0});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_width", 64'(done), 64'd0);
    chk("b2b_busy_after_accept", 64'(busy), 64'd1);
    stable = 1'b1;
    cyc    = 1;
    while (!done && cyc < TMO) begin
      if (quo !== 31'd142 || rem !== 12'd6) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("b2b_outputs_stable", 64'(stable), 64'd1);
    chk("b2b_second_latency", 64'(cyc - 1), 64'd31);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
